// File: rtl/dvs_ravens_pkg.sv
// Shared types and constants for the DVS AER transmit/receive blocks.
package dvs_ravens_pkg;

  localparam int unsigned AER_BITS_DEFAULT = 10;

  typedef enum logic [2:0] {
    IDLE,
    ROW_SETUP,
    ROW_REQ,
    ROW_REL,
    COL_SETUP,
    COL_REQ,
    COL_REL
  } aer_tx_state_t;

  localparam logic XSEL_ROW = 1'b0;
  localparam logic XSEL_COL = 1'b1;

endpackage

// File: rtl/aer_sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level.
module aer_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dvs_aer_event_transmitter.sv
// DVS AER event transmitter: serialises each accepted pixel event as a row
// word followed by a column+polarity word over a 4-phase req/ack handshake.
// Optional macro DVS_AER_ROW_BURST_EN skips the row word when the row matches
// the last fully transmitted event.
module dvs_aer_event_transmitter
  import dvs_ravens_pkg::*;
#(
  parameter int unsigned AER_BITS           = AER_BITS_DEFAULT,
  parameter int unsigned SETUP_CYCLES       = 2,
  parameter int unsigned ACK_TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [AER_BITS-1:0] in_y,
  input  logic [AER_BITS-2:0] in_x,
  input  logic                in_pol,
  output logic [AER_BITS-1:0] aer,
  output logic                xsel,
  output logic                req,
  input  logic                ack,
  output logic                busy,
  output logic                timeout_err
);

  localparam int unsigned WAIT_W = $clog2(ACK_TIMEOUT_CYCLES + 1);
  typedef logic [WAIT_W-1:0] wait_t;
  localparam wait_t      WAIT_LAST  = wait_t'(ACK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES);

  aer_tx_state_t       state, state_n;
  logic [3:0]          setup_cnt, setup_cnt_n;
  wait_t               wait_cnt, wait_cnt_n;
  logic [AER_BITS-1:0] aer_n;
  logic                xsel_n, req_n, tmo_n;
  logic [AER_BITS-1:0] ev_y;
  logic [AER_BITS-2:0] ev_x;
  logic                ev_pol;
  logic                ack_s;
  logic                accept;
  logic                skip_row;
  logic                wait_hit;

  assign accept   = in_valid && in_ready;
  assign wait_hit = (wait_cnt == WAIT_LAST);

  aer_sync_2ff u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack),
    .q   (ack_s)
  );

`ifdef DVS_AER_ROW_BURST_EN
  logic [AER_BITS-1:0] last_y;
  logic                last_y_valid;

  assign skip_row = last_y_valid && (in_y == last_y);

  // Remember the row of the last event whose column word completed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_y       <= '0;
      last_y_valid <= 1'b0;
    end else if (tmo_n) begin
      last_y_valid <= 1'b0;
    end else if (state == COL_REL && !ack_s) begin
      last_y       <= ev_y;
      last_y_valid <= 1'b1;
    end
  end
`else
  assign skip_row = 1'b0;
`endif

  // Capture the event payload on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_y   <= '0;
      ev_x   <= '0;
      ev_pol <= 1'b0;
    end else if (accept) begin
      ev_y   <= in_y;
      ev_x   <= in_x;
      ev_pol <= in_pol;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      setup_cnt   <= '0;
      wait_cnt    <= '0;
      aer         <= '0;
      xsel        <= XSEL_ROW;
      req         <= 1'b0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      setup_cnt   <= setup_cnt_n;
      wait_cnt    <= wait_cnt_n;
      aer         <= aer_n;
      xsel        <= xsel_n;
      req         <= req_n;
      in_ready    <= (state_n == IDLE);
      busy        <= (state_n != IDLE);
      timeout_err <= tmo_n;
    end
  end

  // Next-state and next-output logic. The two words share one code path per
  // phase; the row/column choice is taken from the current state.
  always_comb begin
    state_n     = state;
    setup_cnt_n = setup_cnt;
    wait_cnt_n  = wait_cnt;
    aer_n       = aer;
    xsel_n      = xsel;
    req_n       = req;
    tmo_n       = 1'b0;

    case (state)
      IDLE: begin
        setup_cnt_n = '0;
        wait_cnt_n  = '0;
        if (accept) state_n = skip_row ? COL_SETUP : ROW_SETUP;
      end

      ROW_SETUP, COL_SETUP: begin
        aer_n  = (state == ROW_SETUP) ? ev_y : {ev_x, ev_pol};
        xsel_n = (state == ROW_SETUP) ? XSEL_ROW : XSEL_COL;
        if (ack_s) begin
          // Stale ack from the far side: hold off setup until it releases.
          setup_cnt_n = '0;
          if (wait_hit) begin
            req_n      = 1'b0;
            tmo_n      = 1'b1;
            wait_cnt_n = '0;
            state_n    = IDLE;
          end else begin
            wait_cnt_n = wait_cnt + wait_t'(1);
          end
        end else begin
          wait_cnt_n = '0;
          if (setup_cnt == SETUP_LAST) begin
            req_n       = 1'b1;
            setup_cnt_n = '0;
            state_n     = (state == ROW_SETUP) ? ROW_REQ : COL_REQ;
          end else begin
            setup_cnt_n = setup_cnt + 4'd1;
          end
        end
      end

      ROW_REQ, COL_REQ: begin
        if (ack_s) begin
          req_n      = 1'b0;
          wait_cnt_n = '0;
          state_n    = (state == ROW_REQ) ? ROW_REL : COL_REL;
        end else if (wait_hit) begin
          req_n      = 1'b0;
          tmo_n      = 1'b1;
          wait_cnt_n = '0;
          state_n    = IDLE;
        end else begin
          wait_cnt_n = wait_cnt + wait_t'(1);
        end
      end

      ROW_REL, COL_REL: begin
        if (!ack_s) begin
          wait_cnt_n = '0;
          state_n    = (state == ROW_REL) ? COL_SETUP : IDLE;
        end else if (wait_hit) begin
          req_n      = 1'b0;
          tmo_n      = 1'b1;
          wait_cnt_n = '0;
          state_n    = IDLE;
        end else begin
          wait_cnt_n = wait_cnt + wait_t'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dvs_aer_event_transmitter.sv
// Self-checking bench for dvs_aer_event_transmitter (optionally built with
// DVS_AER_ROW_BURST_EN).
module tb_dvs_aer_event_transmitter;

`ifdef DVS_AER_ROW_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk, rst, in_valid, in_ready, in_pol, xsel, req, ack, busy, timeout_err;
  logic [9:0] in_y, aer;
  logic [8:0] in_x;

  dvs_aer_event_transmitter #(
    .AER_BITS           (10),
    .SETUP_CYCLES       (2),
    .ACK_TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_y        (in_y),
    .in_x        (in_x),
    .in_pol      (in_pol),
    .aer         (aer),
    .xsel        (xsel),
    .req         (req),
    .ack         (ack),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int checks = 0;
  int failures = 0;

  // Words are {xsel, aer}.
  logic [10:0] obs_q[$];
  logic [10:0] exp_q[$];
  longint      rise_tq[$];
  longint      fall_t = 0;
  longint      acc_t = 0;
  logic        busy_at_acc = 1'b0;
  int          n_rise = 0;
  int          n_tmo = 0;
  int          viol = 0;
  int          ack_mode = 0;   // 0 auto, 1 held low, 2 manual
  int          ack_delay = 3;
  logic [9:0]  m_last_y = '0;
  bit          m_last_valid = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req_v);
    end
  endtask

  // Reference model: what the link should carry for one event.
  function automatic void model_event(input logic [9:0] y, input logic [8:0] x, input logic pol);
    if (!(BURST && m_last_valid && y == m_last_y)) exp_q.push_back({1'b0, y});
    exp_q.push_back({1'b1, x, pol});
    m_last_y     = y;
    m_last_valid = 1'b1;
  endfunction

  // Ack responder: mirrors req after ack_delay cycles when in auto mode.
  initial begin
    int lag;
    lag = 0;
    ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_mode == 0) begin
        if (req !== ack) begin
          lag++;
          if (lag >= ack_delay) begin
            ack = req;
            lag = 0;
          end
        end else begin
          lag = 0;
        end
      end else begin
        lag = 0;
        if (ack_mode == 1) ack = 1'b0;
      end
    end
  end

  // Link monitor: records words, edge times, timeout pulses and bus stability.
  initial begin
    logic        req_q, locked;
    logic [10:0] lock_w;
    req_q  = 1'b0;
    locked = 1'b0;
    lock_w = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        locked = 1'b0;
      end else begin
        if (req && !req_q) begin
          obs_q.push_back({xsel, aer});
          rise_tq.push_back($time - 5);
          lock_w = {xsel, aer};
          locked = 1'b1;
          n_rise++;
        end
        if (!req && req_q) fall_t = $time - 5;
        if (locked && {xsel, aer} !== lock_w) viol++;
        if (locked && !req && !ack) locked = 1'b0;
        if (timeout_err) n_tmo++;
      end
      req_q = req;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // Present one event (called at a negedge); returns one negedge after accept.
  task automatic send(input logic [9:0] y, input logic [8:0] x, input logic pol, input bit use_model);
    bit ok;
    ok       = 1'b0;
    in_y     = y;
    in_x     = x;
    in_pol   = pol;
    in_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      acc_t       = $time;
      busy_at_acc = busy;
      if (use_model) model_event(y, x, pol);
    end
    chk("accept", ok, 1);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && in_ready && !req && !ack) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, " idle"}, ok, 1);
  endtask

  task automatic compare_words(input string nm);
    logic [10:0] o, e;
    chk({nm, " word_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({nm, " word"}, o, e);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic [9:0] y;
    logic [8:0] x;
    logic       pol;
    logic [9:0] row_aer;
    logic [9:0] col_aer;
  } vec_t;

  initial begin
    vec_t        vecs[5];
    int          base;
    logic [10:0] w;
    logic [9:0]  ry;
    logic [8:0]  rx;
    logic        rp;

    vecs[0] = '{y: 10'd37,   x: 9'd100, pol: 1'b1, row_aer: 10'd37,   col_aer: 10'd201};
    vecs[1] = '{y: 10'd0,    x: 9'd0,   pol: 1'b0, row_aer: 10'd0,    col_aer: 10'd0};
    vecs[2] = '{y: 10'd1023, x: 9'd511, pol: 1'b1, row_aer: 10'd1023, col_aer: 10'd1023};
    vecs[3] = '{y: 10'd512,  x: 9'd256, pol: 1'b0, row_aer: 10'd512,  col_aer: 10'd512};
    vecs[4] = '{y: 10'd1,    x: 9'd1,   pol: 1'b0, row_aer: 10'd1,    col_aer: 10'd2};

    rst = 1'b1; in_valid = 1'b0; in_y = '0; in_x = '0; in_pol = 1'b0;
    @(negedge clk);
    chk("rst in_ready", in_ready, 0);
    chk("rst aer", aer, 0);
    chk("rst xsel", xsel, 0);
    chk("rst req", req, 0);
    chk("rst busy", busy, 0);
    chk("rst timeout_err", timeout_err, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("first cycle in_ready", in_ready, 0);
    @(negedge clk);
    chk("in_ready after first cycle", in_ready, 1);

    // Table of single events with hand-computed words.
    ack_delay = 3;
    for (int i = 0; i < 5; i++) begin
      rise_tq.delete();
      send(vecs[i].y, vecs[i].x, vecs[i].pol, 1'b0);
      in_valid = 1'b0;
      wait_idle("table");
      chk("table word_count", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
        w = obs_q.pop_front();
        chk("table row_word", w, {1'b0, vecs[i].row_aer});
        w = obs_q.pop_front();
        chk("table col_word", w, {1'b1, vecs[i].col_aer});
      end
      if (i == 0 && rise_tq.size() > 0)
        chk("first req latency", (rise_tq[0] - (acc_t + 5)) / 10, 3);
      obs_q.delete();
    end
    m_last_y = vecs[4].y;
    m_last_valid = 1'b1;

    // Back-to-back: in_valid held high across four events.
    base = n_rise;
    viol = 0;
    for (int i = 0; i < 4; i++) begin
      send(10'(10 + i), 9'(20 + i), 1'(i), 1'b1);
      chk("b2b accept only when idle", busy_at_acc, 0);
    end
    in_valid = 1'b0;
    wait_idle("b2b");
    chk("b2b handshakes", n_rise - base, 8);
    chk("b2b aer stable", viol, 0);
    compare_words("b2b");

    // Timeout: ack held low.
    ack_mode = 1;
    base = n_tmo;
    send(10'd77, 9'd5, 1'b0, 1'b0);
    in_valid = 1'b0;
    exp_q.push_back({1'b0, 10'd77});
    m_last_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (n_tmo != base) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("timeout pulses", n_tmo - base, 1);
    if (rise_tq.size() > 0) chk("timeout req width", (fall_t - rise_tq[$]) / 10, 16);
    chk("timeout busy", busy, 0);
    chk("timeout in_ready", in_ready, 1);
    chk("timeout req", req, 0);
    compare_words("timeout");
    ack_mode = 0;
    send(10'd78, 9'd6, 1'b1, 1'b1);
    in_valid = 1'b0;
    wait_idle("after timeout");
    compare_words("after timeout");

    // Stale ack high when the event is accepted.
    ack_mode = 2;
    ack = 1'b1;
    repeat (4) @(negedge clk);
    base = n_rise;
    send(10'd300, 9'd44, 1'b1, 1'b1);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("stale req held low", n_rise - base, 0);
    chk("stale req", req, 0);
    ack = 1'b0;
    ack_mode = 0;
    wait_idle("stale");
    compare_words("stale");

    // Reset during the column request.
    send(10'd400, 9'd99, 1'b0, 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (req && xsel) break;
      @(negedge clk);
    end
    chk("reached col req", req && xsel, 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst req", req, 0);
    chk("async rst aer", aer, 0);
    chk("async rst xsel", xsel, 0);
    chk("async rst in_ready", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post rst in_ready first cycle", in_ready, 0);
    @(negedge clk);
    chk("post rst in_ready", in_ready, 1);
    m_last_valid = 1'b0;
    wait_idle("reset");
    compare_words("reset");

    // Row burst sequence.
    base = n_rise;
    send(10'd5, 9'd1, 1'b0, 1'b1);
    send(10'd5, 9'd2, 1'b1, 1'b1);
    send(10'd6, 9'd3, 1'b0, 1'b1);
    in_valid = 1'b0;
    wait_idle("burst");
    chk("burst handshakes", n_rise - base, BURST ? 5 : 6);
    compare_words("burst");

    // Randomised events against the model.
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      ack_delay = int'($urandom_range(1, 5));
      ry = 10'($urandom_range(0, 3));
      rx = 9'($urandom);
      rp = 1'($urandom);
      send(ry, rx, rp, 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
    wait_idle("random");
    compare_words("random");
    chk("random aer stable", viol, 0);
    chk("total timeouts", n_tmo, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
